// File: rtl/commit_pkg.sv
// Shared constants and types for the custom-0 commit unit.
package commit_pkg;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

  localparam logic [6:0] F_SRC  = 7'h18;
  localparam logic [6:0] F_DST  = 7'h19;
  localparam logic [6:0] F_STEP = 7'h1A;
  localparam logic [6:0] F_CHAN = 7'h1B;
  localparam logic [6:0] F_LEN  = 7'h20;
  localparam logic [6:0] F_EXEC = 7'h2B;

  localparam logic [1:0] MODE_MOVE      = 2'b00;
  localparam logic [1:0] MODE_MOVE_BACK = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EXEC_WAIT = 2'd1,
    ST_RSP       = 2'd2
  } commit_state_e;

  // Which operand register a configuration instruction targets.
  typedef enum logic [2:0] {
    SEL_SRC  = 3'd0,
    SEL_DST  = 3'd1,
    SEL_STEP = 3'd2,
    SEL_CHAN = 3'd3,
    SEL_LEN  = 3'd4
  } cfg_sel_e;

endpackage

// File: rtl/commit_decode.sv
// Pure combinational decode of the instruction fields into an action class.
module commit_decode
  import commit_pkg::*;
#(
  parameter logic [6:0] OPCODE = OPCODE_CUSTOM0
) (
  input  logic [6:0] opcode_i,
  input  logic [6:0] funct7_i,
  input  logic [1:0] mode_i,
  output logic       is_cfg_o,
  output cfg_sel_e   cfg_sel_o,
  output logic       is_exec_o,
  output logic       illegal_o
);

  // Classify the instruction; anything not a cfg write or legal EXEC is illegal.
  always_comb begin
    is_cfg_o  = 1'b0;
    cfg_sel_o = SEL_SRC;
    is_exec_o = 1'b0;
    if (opcode_i == OPCODE) begin
      case (funct7_i)
        F_SRC:  begin is_cfg_o = 1'b1; cfg_sel_o = SEL_SRC;  end
        F_DST:  begin is_cfg_o = 1'b1; cfg_sel_o = SEL_DST;  end
        F_STEP: begin is_cfg_o = 1'b1; cfg_sel_o = SEL_STEP; end
        F_CHAN: begin is_cfg_o = 1'b1; cfg_sel_o = SEL_CHAN; end
        F_LEN:  begin is_cfg_o = 1'b1; cfg_sel_o = SEL_LEN;  end
        F_EXEC: is_exec_o = (mode_i == MODE_MOVE) || (mode_i == MODE_MOVE_BACK);
        default: ;
      endcase
    end
    illegal_o = !is_cfg_o && !is_exec_o;
  end

endmodule

// File: rtl/commit_unit.sv
// Custom-0 commit unit: latches operand registers, launches the move engine
// on EXEC, and returns exactly one response per accepted instruction.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The request side is ready only in IDLE; the response side
// holds rsp_vaild/rsp_err stable until rsp_ready is sampled high.
module commit_unit
  import commit_pkg::*;
#(
  parameter logic [6:0] OPCODE = OPCODE_CUSTOM0,
  parameter int         IMM_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_vaild,
  output logic             req_ready,
  input  logic [31:0]      r_in,
  output logic             rsp_vaild,
  input  logic             rsp_ready,
  output logic             rsp_err,
  output logic [IMM_W-1:0] cfg_src,
  output logic [IMM_W-1:0] cfg_dst,
  output logic [IMM_W-1:0] cfg_step,
  output logic [IMM_W-1:0] cfg_chan,
  output logic [IMM_W-1:0] cfg_len,
  output logic             op_start,
  output logic [1:0]       op_mode,
  input  logic             op_done,
  output commit_state_e    state_o
);

  commit_state_e    state_q, state_d;
  logic [IMM_W-1:0] cfg_src_q, cfg_src_d, cfg_dst_q, cfg_dst_d;
  logic [IMM_W-1:0] cfg_step_q, cfg_step_d, cfg_chan_q, cfg_chan_d;
  logic [IMM_W-1:0] cfg_len_q, cfg_len_d;
  logic [1:0]       op_mode_q, op_mode_d;
  logic             op_start_q, op_start_d;
  logic             rsp_err_q, rsp_err_d;

  logic             is_cfg, is_exec, illegal, accept;
  cfg_sel_e         cfg_sel;
  logic [IMM_W-1:0] imm;
  logic             unused_rsvd;

  assign imm         = r_in[7 +: IMM_W];
  assign unused_rsvd = ^r_in[24:23];

  commit_decode #(.OPCODE(OPCODE)) u_decode (
    .opcode_i  (r_in[6:0]),
    .funct7_i  (r_in[31:25]),
    .mode_i    (r_in[8:7]),
    .is_cfg_o  (is_cfg),
    .cfg_sel_o (cfg_sel),
    .is_exec_o (is_exec),
    .illegal_o (illegal)
  );

  assign accept = req_vaild && (state_q == ST_IDLE);

  // State and register update; reset aborts any in-flight instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cfg_src_q  <= '0;
      cfg_dst_q  <= '0;
      cfg_step_q <= '0;
      cfg_chan_q <= '0;
      cfg_len_q  <= '0;
      op_mode_q  <= 2'b00;
      op_start_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_src_q  <= cfg_src_d;
      cfg_dst_q  <= cfg_dst_d;
      cfg_step_q <= cfg_step_d;
      cfg_chan_q <= cfg_chan_d;
      cfg_len_q  <= cfg_len_d;
      op_mode_q  <= op_mode_d;
      op_start_q <= op_start_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Next-state logic: accept in IDLE, wait for the engine, hold the response.
  always_comb begin
    state_d    = state_q;
    cfg_src_d  = cfg_src_q;
    cfg_dst_d  = cfg_dst_q;
    cfg_step_d = cfg_step_q;
    cfg_chan_d = cfg_chan_q;
    cfg_len_d  = cfg_len_q;
    op_mode_d  = op_mode_q;
    op_start_d = 1'b0;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (illegal) begin
            state_d   = ST_RSP;
            rsp_err_d = 1'b1;
          end else if (is_cfg) begin
            state_d   = ST_RSP;
            rsp_err_d = 1'b0;
            case (cfg_sel)
              SEL_SRC:  cfg_src_d  = imm;
              SEL_DST:  cfg_dst_d  = imm;
              SEL_STEP: cfg_step_d = imm;
              SEL_CHAN: cfg_chan_d = imm;
              SEL_LEN:  cfg_len_d  = imm;
              default:  ;
            endcase
          end else if (is_exec) begin
            state_d    = ST_EXEC_WAIT;
            op_mode_d  = r_in[8:7];
            op_start_d = 1'b1;
          end
        end
      end
      ST_EXEC_WAIT: begin
        // op_done coinciding with the launch pulse belongs to nothing we started.
        if (!op_start_q && op_done) begin
          state_d   = ST_RSP;
          rsp_err_d = 1'b0;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_d   = ST_IDLE;
          rsp_err_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_vaild = (state_q == ST_RSP);
  assign rsp_err   = rsp_err_q;
  assign op_start  = op_start_q;
  assign op_mode   = op_mode_q;
  assign cfg_src   = cfg_src_q;
  assign cfg_dst   = cfg_dst_q;
  assign cfg_step  = cfg_step_q;
  assign cfg_chan  = cfg_chan_q;
  assign cfg_len   = cfg_len_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: inputs change at posedge+1, outputs are
// checked on the falling edge.
module tb_commit_unit;
  import commit_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_vaild = 1'b0;
  logic          req_ready;
  logic [31:0]   r_in = '0;
  logic          rsp_vaild;
  logic          rsp_ready = 1'b0;
  logic          rsp_err;
  logic [15:0]   cfg_src, cfg_dst, cfg_step, cfg_chan, cfg_len;
  logic          op_start;
  logic [1:0]    op_mode;
  logic          op_done = 1'b0;
  commit_state_e state_o;

  int checks = 0;
  int errors = 0;

  commit_unit dut (
    .clk       (clk),
    .reset     (reset),
    .req_vaild (req_vaild),
    .req_ready (req_ready),
    .r_in      (r_in),
    .rsp_vaild (rsp_vaild),
    .rsp_ready (rsp_ready),
    .rsp_err   (rsp_err),
    .cfg_src   (cfg_src),
    .cfg_dst   (cfg_dst),
    .cfg_step  (cfg_step),
    .cfg_chan  (cfg_chan),
    .cfg_len   (cfg_len),
    .op_start  (op_start),
    .op_mode   (op_mode),
    .op_done   (op_done),
    .state_o   (state_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [15:0] imm,
                                     input logic [6:0] opc);
    return {f7, 2'b00, imm, opc};
  endfunction

  // Drive one instruction for one cycle; the unit is expected to be in IDLE.
  task automatic drive_instr(input logic [31:0] w);
    @(negedge clk);
    req_vaild = 1'b1;
    r_in      = w;
    @(posedge clk);
    #1 req_vaild = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b need 1", req_ready); end
    checks++; if (rsp_vaild !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp: got v=%b e=%b need 0/0", rsp_vaild, rsp_err); end
    checks++; if (op_start !== 1'b0 || op_mode !== 2'b00) begin errors++; $display("FAIL reset_op: got start=%b mode=%b need 0/00", op_start, op_mode); end
    checks++; if ({cfg_src, cfg_dst, cfg_step, cfg_chan, cfg_len} !== 80'h0) begin errors++; $display("FAIL reset_cfg: got %h need 0", {cfg_src, cfg_dst, cfg_step, cfg_chan, cfg_len}); end
    checks++; if (state_o !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d need %0d", state_o, ST_IDLE); end
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_cfg_writes();
    logic [6:0]  f7s [5] = '{F_SRC, F_DST, F_STEP, F_CHAN, F_LEN};
    logic [15:0] imms[5] = '{16'd6, 16'd2, 16'd1, 16'd12, 16'd16};
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_instr(mk(f7s[i], imms[i], OPCODE_CUSTOM0));
      @(negedge clk);
      checks++; if (rsp_vaild !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL cfg_rsp[%0d]: got v=%b e=%b need 1/0", i, rsp_vaild, rsp_err); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL cfg_busy[%0d]: got req_ready=%b need 0", i, req_ready); end
      @(negedge clk);
      checks++; if (rsp_vaild !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL cfg_idle[%0d]: got v=%b rdy=%b need 0/1", i, rsp_vaild, req_ready); end
    end
    checks++; if (cfg_src !== 16'd6 || cfg_dst !== 16'd2 || cfg_step !== 16'd1 || cfg_chan !== 16'd12 || cfg_len !== 16'd16) begin
      errors++; $display("FAIL cfg_values: got %0d %0d %0d %0d %0d need 6 2 1 12 16", cfg_src, cfg_dst, cfg_step, cfg_chan, cfg_len);
    end
  endtask

  task automatic test_exec_mode0();
    rsp_ready = 1'b1;
    drive_instr(mk(F_EXEC, 16'h0000, OPCODE_CUSTOM0));
    @(negedge clk);
    checks++; if (op_start !== 1'b1 || op_mode !== MODE_MOVE) begin errors++; $display("FAIL exec0_start: got start=%b mode=%b need 1/00", op_start, op_mode); end
    checks++; if (req_ready !== 1'b0 || rsp_vaild !== 1'b0) begin errors++; $display("FAIL exec0_busy: got rdy=%b v=%b need 0/0", req_ready, rsp_vaild); end
    // op_done during the launch cycle must be ignored.
    op_done = 1'b1;
    @(posedge clk); #1 op_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (op_start !== 1'b0 || rsp_vaild !== 1'b0 || req_ready !== 1'b0) begin
        errors++; $display("FAIL exec0_wait[%0d]: got start=%b v=%b rdy=%b need 0/0/0", c, op_start, rsp_vaild, req_ready);
      end
    end
    @(negedge clk);
    op_done = 1'b1;
    @(posedge clk); #1 op_done = 1'b0;
    @(negedge clk);
    checks++; if (rsp_vaild !== 1'b1 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL exec0_rsp: got v=%b e=%b rdy=%b need 1/0/0", rsp_vaild, rsp_err, req_ready); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || rsp_vaild !== 1'b0) begin errors++; $display("FAIL exec0_idle: got rdy=%b v=%b need 1/0", req_ready, rsp_vaild); end
  endtask

  task automatic test_exec_mode1_stall();
    rsp_ready = 1'b0;
    drive_instr(mk(F_EXEC, 16'h0001, OPCODE_CUSTOM0));
    @(negedge clk);
    checks++; if (op_start !== 1'b1 || op_mode !== MODE_MOVE_BACK) begin errors++; $display("FAIL exec1_start: got start=%b mode=%b need 1/01", op_start, op_mode); end
    @(negedge clk);
    op_done = 1'b1;
    @(posedge clk); #1 op_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (rsp_vaild !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL exec1_hold[%0d]: got v=%b e=%b need 1/0", c, rsp_vaild, rsp_err); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (state_o !== ST_IDLE || rsp_vaild !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL exec1_idle: got st=%0d v=%b rdy=%b need 0/0/1", state_o, rsp_vaild, req_ready);
    end
    checks++; if (op_mode !== MODE_MOVE_BACK) begin errors++; $display("FAIL exec1_mode_hold: got %b need 01", op_mode); end
  endtask

  task automatic test_illegal();
    logic [31:0] words[3];
    words[0] = mk(F_SRC, 16'hBEEF, 7'h33);
    words[1] = mk(7'h7F, 16'hBEEF, OPCODE_CUSTOM0);
    words[2] = mk(F_EXEC, 16'h0003, OPCODE_CUSTOM0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_instr(words[i]);
      @(negedge clk);
      checks++; if (rsp_vaild !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL illegal_rsp[%0d]: got v=%b e=%b need 1/1", i, rsp_vaild, rsp_err); end
      checks++; if (op_start !== 1'b0) begin errors++; $display("FAIL illegal_start[%0d]: got %b need 0", i, op_start); end
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL illegal_idle[%0d]: got rdy=%b need 1", i, req_ready); end
    end
    checks++; if (cfg_src !== 16'd6 || cfg_dst !== 16'd2 || cfg_step !== 16'd1 || cfg_chan !== 16'd12 || cfg_len !== 16'd16 || op_mode !== 2'b01) begin
      errors++; $display("FAIL illegal_regs: got %0d %0d %0d %0d %0d mode=%b need 6 2 1 12 16 mode=01", cfg_src, cfg_dst, cfg_step, cfg_chan, cfg_len, op_mode);
    end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0;
    @(negedge clk);
    req_vaild = 1'b1;
    r_in      = mk(F_SRC, 16'h1234, OPCODE_CUSTOM0);
    @(posedge clk);
    #1 r_in = mk(F_DST, 16'h5678, OPCODE_CUSTOM0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (req_ready !== 1'b0 || cfg_dst !== 16'd2) begin errors++; $display("FAIL b2b_blocked[%0d]: got rdy=%b dst=%h need 0/0002", c, req_ready, cfg_dst); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || rsp_vaild !== 1'b0 || cfg_dst !== 16'd2) begin
      errors++; $display("FAIL b2b_release: got rdy=%b v=%b dst=%h need 1/0/0002", req_ready, rsp_vaild, cfg_dst);
    end
    @(posedge clk);
    #1 req_vaild = 1'b0;
    @(negedge clk);
    checks++; if (cfg_dst !== 16'h5678 || cfg_src !== 16'h1234 || rsp_vaild !== 1'b1) begin
      errors++; $display("FAIL b2b_second: got src=%h dst=%h v=%b need 1234/5678/1", cfg_src, cfg_dst, rsp_vaild);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_exec();
    rsp_ready = 1'b1;
    drive_instr(mk(F_EXEC, 16'h0001, OPCODE_CUSTOM0));
    @(negedge clk);
    @(negedge clk);
    checks++; if (state_o !== ST_EXEC_WAIT) begin errors++; $display("FAIL rst_mid_pre: got st=%0d need %0d", state_o, ST_EXEC_WAIT); end
    #2 reset = 1'b0;
    #1;
    checks++; if (state_o !== ST_IDLE || req_ready !== 1'b1 || rsp_vaild !== 1'b0 || op_mode !== 2'b00 || cfg_src !== 16'h0) begin
      errors++; $display("FAIL rst_mid_async: got st=%0d rdy=%b v=%b mode=%b src=%h need 0/1/0/00/0000", state_o, req_ready, rsp_vaild, op_mode, cfg_src);
    end
    @(negedge clk);
    reset   = 1'b1;
    op_done = 1'b1;
    @(posedge clk); #1 op_done = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (rsp_vaild !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_after[%0d]: got v=%b rdy=%b need 0/1", c, rsp_vaild, req_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_cfg_writes();
    test_exec_mode0();
    test_exec_mode1_stall();
    test_illegal();
    test_back_to_back();
    test_reset_mid_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/commit_unit.md
Name: commit_unit

Overview:
- Single-clock custom-instruction commit unit for the DSP coprocessor.
- Accepts 32-bit custom-0 instructions over a valid/ready request channel.
- Configuration instructions latch 16-bit immediates into operand registers. EXEC instructions launch the data-move engine and wait for it to finish.
- Returns one response per instruction on a valid/ready response channel.

Parameters:
- OPCODE, 7'b0001011, major opcode that marks a valid instruction (custom-0).
- IMM_W, 16, width of the immediate field and of each operand register.

Ports:
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-low reset.
- req_vaild  in  1  instruction valid.
- req_ready  out  1  unit can accept an instruction.
- r_in  in  32  instruction word. Fields: [31:25] funct7, [24:23] reserved, [22:7] imm16, [6:0] opcode. For EXEC, mode = [8:7].
- rsp_vaild  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_err  out  1  qualifies rsp_vaild: the instruction was illegal.
- cfg_src  out  16  operand register 0x18.
- cfg_dst  out  16  operand register 0x19.
- cfg_step  out  16  operand register 0x1A.
- cfg_chan  out  16  operand register 0x1B.
- cfg_len  out  16  operand register 0x20.
- op_start  out  1  one-cycle pulse that launches the move engine.
- op_mode  out  2  mode latched from the EXEC instruction.
- op_done  in  1  engine completion pulse or level.

Behaviour:
- Reset (asynchronous, reset=0): all cfg_* = 0, op_mode = 0, op_start = 0, rsp_vaild = 0, rsp_err = 0, state = IDLE. req_ready follows the state, so it is 1 in reset.
- States: IDLE, EXEC_WAIT, RSP.
- req_ready = 1 only in IDLE. An instruction is accepted when req_vaild & req_ready on a rising clk edge, and r_in is sampled on that edge.
- Decode on acceptance:
  - opcode != OPCODE: illegal.
  - funct7 0x18/0x19/0x1A/0x1B/0x20: write imm16 into the matching cfg register at the accept edge, then go to RSP with rsp_err = 0. rsp_vaild is high the cycle after acceptance (latency 1).
  - funct7 0x2B (EXEC), mode 00 or 01: op_mode <= mode; op_start = 1 for exactly the cycle after acceptance; go to EXEC_WAIT.
  - EXEC with mode 10 or 11: illegal.
  - Any other funct7: illegal.
  - Illegal instruction: no register changes, no op_start; go to RSP with rsp_err = 1.
- EXEC_WAIT: remain until op_done = 1 is sampled, then go to RSP with rsp_err = 0.
  - op_done is ignored during the op_start cycle itself. Sampling starts the cycle after op_start.
  - op_done seen in any other state is ignored.
- RSP: rsp_vaild = 1 and rsp_err stable until rsp_ready = 1 is sampled. Then go to IDLE and drop rsp_vaild, so at most one response is outstanding.
  - The earliest next acceptance is the cycle after the response handshake.
  - rsp_ready already high when rsp_vaild rises completes the handshake at that edge.
- Reset asserted mid-operation aborts immediately: state returns to IDLE and no response is produced for the in-flight instruction.
- cfg registers hold their values across EXEC. Only their own funct7 writes them.
- req_vaild during a non-IDLE state is not accepted. The requester holds r_in stable until req_ready.

Decomposition:
- Shared package commit_pkg holds:
  - OPCODE_CUSTOM0 = 7'b0001011.
  - funct7 constants F_SRC = 7'h18, F_DST = 7'h19, F_STEP = 7'h1A, F_CHAN = 7'h1B, F_LEN = 7'h20, F_EXEC = 7'h2B.
  - Mode constants MODE_MOVE = 2'b00, MODE_MOVE_BACK = 2'b01.
  - The state enum.
- One combinational sub-module, commit_decode: r_in -> {is_cfg, cfg_sel, is_exec, illegal}. The FSM and registers stay in commit_unit.

Test Plan:
- Reset, then send the five cfg words in order: 0x18/imm 6, 0x19/imm 2, 0x1A/imm 1, 0x1B/imm 12, 0x20/imm 16. Required: each gets rsp_vaild one cycle after acceptance with rsp_err = 0, and finally cfg_src = 6, cfg_dst = 2, cfg_step = 1, cfg_chan = 12, cfg_len = 16.
- EXEC mode 00, with op_done returned 5 cycles later. Required: a single op_start pulse the cycle after acceptance, op_mode = 00, req_ready = 0 until the response completes, rsp_vaild the cycle after op_done.
- EXEC mode 01, with rsp_ready held low 3 cycles. Required: op_mode = 01, rsp_vaild held for those 3 cycles, IDLE re-entered after the handshake.
- Illegal instructions, one each: opcode 0x33; funct7 0x7F; EXEC mode 11. Required: rsp_err = 1, cfg registers unchanged, no op_start.
- Back-to-back requests with req_vaild held high. Required: the second instruction is accepted only after the first response handshake.
- reset pulsed low while in EXEC_WAIT. Required: outputs return to reset values asynchronously, no response, req_ready = 1 after release.
